c17_pipe_array: RTL
===================

Name: c17_pipe_array

Overview:
- W-channel, bit-sliced, fully path-balanced pipelined implementation of the c17 function.
- Every gate level is a register stage. Every signal that skips a level is carried through balancing flops, so all paths are equal length.
- Valid/ready handshake on both sides; saturating count of delivered beats.
- Clocked successor of the buffer-inserted combinational c17 netlists; serves as a sequential regression target for the insertion flow.

Parameters:
- W, 4, number of independent bit channels (each input/output bus is W bits).
- EXTRA_STAGES, 0, additional pure-delay register stages appended after logic level 3 (0..8).
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  pipeline can accept a beat this cycle.
- n1  input  W  c17 input N1 per channel.
- n2  input  W  c17 input N2 per channel.
- n3  input  W  c17 input N3 per channel.
- n6  input  W  c17 input N6 per channel.
- n7  input  W  c17 input N7 per channel.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts output.
- n22  output  W  c17 output N22 per channel.
- n23  output  W  c17 output N23 per channel.
- beat_cnt  output  CNT_W  number of accepted output beats, saturating.

Behaviour:
- Function, per channel i:
  - n22 = (N1&N3) | (N2 & ~(N3&N6))
  - n23 = ~(N3&N6) & (N2|N7)
- Level 1 registers: a = ~(N1&N3), b = ~(N3&N6). N2 and N7 are also registered (balancing).
- Level 2 registers: c = ~(N2&b), d = ~(b&N7). a is carried (balancing).
- Level 3 registers: N22 = ~(a&c), N23 = ~(c&d).
- Then EXTRA_STAGES delay stages.
- Total latency L = 3 + EXTRA_STAGES cycles from accepted input to out_valid, with no stall.
- Each stage holds a valid bit; data registers load only when the stage advances.
- Global advance: adv = ~out_valid | out_ready. On adv, all stages shift by one; stage-1 valid takes in_valid.
- in_ready = adv (combinational). An input is accepted when in_valid & in_ready.
- No stall: throughput is 1 beat/cycle.
- Stall (out_valid & ~out_ready): the whole pipe freezes and holds n22/n23 stable. Internal bubbles are not collapsed.
- beat_cnt increments on out_valid & out_ready and saturates at 2^CNT_W-1.
- Reset (async, any time, including mid-stream): all valid bits 0, out_valid 0, n22/n23 0, beat_cnt 0, in_ready 1 after release. In-flight beats are discarded.
- Data registers are cleared to 0 on reset, so outputs are never X.
- in_valid=0 while adv: a bubble propagates and out_valid is 0 for the matching cycle.
- Channels are fully independent; no cross-channel logic.

Optional Feature:
- Macro: C17_PIPE_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = XOR reduction of {n22, n23} for the beat currently presented.
  - out_par is registered in the final stage together with the data and has the same latency.
  - Reset value 0.
- Undefined: port absent; no parity logic; all other behaviour identical.

Test Plan:
- W=4, EXTRA_STAGES=0, out_ready=1: all inputs 0 -> after 3 cycles out_valid=1, n22=0x0, n23=0x0; beat_cnt=1 one cycle later.
- All inputs 0xF -> n22=0xF, n23=0x0. Inputs n2=0xF, others 0 -> n22=0xF, n23=0xF. Both at latency 3.
- Per-channel mix n1=0x1, n2=0x2, n3=0x5, n6=0x4, n7=0x8 (ch0:N1,N3; ch1:N2; ch2:N3,N6; ch3:N7) -> n22=0x3, n23=0xA.
- 10 back-to-back beats with out_ready held 0 from cycle 5 to 8 -> output frozen while stalled, in_ready=0, no beats lost or duplicated, beat_cnt=10 at end.
- EXTRA_STAGES=2: single beat -> out_valid exactly 5 cycles after acceptance. Assert rst while 3 beats in flight -> out_valid=0 immediately, no stale beat emerges after release, beat_cnt=0.
- CNT_W=2: 5 accepted beats -> beat_cnt saturates at 3. With C17_PIPE_PARITY_EN, n22=0x3, n23=0xA -> out_par=0.

Source files
------------

// File: rtl/c17_pipe_array.sv
// W-channel path-balanced pipelined c17 with valid/ready handshake and saturating beat counter.
// Optional out_par output enabled by defining C17_PIPE_PARITY_EN.
module c17_pipe_array #(
  parameter int unsigned W            = 4,
  parameter int unsigned EXTRA_STAGES = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     n1,
  input  logic [W-1:0]     n2,
  input  logic [W-1:0]     n3,
  input  logic [W-1:0]     n6,
  input  logic [W-1:0]     n7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     n22,
  output logic [W-1:0]     n23,
`ifdef C17_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] beat_cnt
);

  // Tail = logic level 3 followed by the pure-delay stages.
  localparam int unsigned NT = EXTRA_STAGES + 1;

  logic             adv;

  logic             v1_q, v1_d;
  logic [W-1:0]     a1_q, a1_d, b1_q, b1_d, n2r_q, n2r_d, n7r_q, n7r_d;

  logic             v2_q, v2_d;
  logic [W-1:0]     c2_q, c2_d, d2_q, d2_d, a2_q, a2_d;

  logic             tv_q  [NT];
  logic             tv_d  [NT];
  logic [W-1:0]     t22_q [NT];
  logic [W-1:0]     t22_d [NT];
  logic [W-1:0]     t23_q [NT];
  logic [W-1:0]     t23_d [NT];
`ifdef C17_PIPE_PARITY_EN
  logic             tpar_q [NT];
  logic             tpar_d [NT];
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     l3_22, l3_23;

  assign out_valid = tv_q[NT-1];
  assign n22       = t22_q[NT-1];
  assign n23       = t23_q[NT-1];
  assign beat_cnt  = cnt_q;
  assign in_ready  = adv;
`ifdef C17_PIPE_PARITY_EN
  assign out_par   = tpar_q[NT-1];
`endif

  // Next-state: whole pipe shifts together on adv, otherwise everything holds.
  always_comb begin
    adv   = ~tv_q[NT-1] | out_ready;
    l3_22 = ~(a2_q & c2_q);
    l3_23 = ~(c2_q & d2_q);

    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    n2r_d = n2r_q;
    n7r_d = n7r_q;
    v2_d  = v2_q;
    c2_d  = c2_q;
    d2_d  = d2_q;
    a2_d  = a2_q;
    for (int unsigned k = 0; k < NT; k++) begin
      tv_d[k]  = tv_q[k];
      t22_d[k] = t22_q[k];
      t23_d[k] = t23_q[k];
`ifdef C17_PIPE_PARITY_EN
      tpar_d[k] = tpar_q[k];
`endif
    end

    if (adv) begin
      v1_d     = in_valid;
      a1_d     = ~(n1 & n3);
      b1_d     = ~(n3 & n6);
      n2r_d    = n2;
      n7r_d    = n7;
      v2_d     = v1_q;
      c2_d     = ~(n2r_q & b1_q);
      d2_d     = ~(b1_q & n7r_q);
      a2_d     = a1_q;
      tv_d[0]  = v2_q;
      t22_d[0] = l3_22;
      t23_d[0] = l3_23;
`ifdef C17_PIPE_PARITY_EN
      tpar_d[0] = ^{l3_22, l3_23};
`endif
      for (int unsigned k = 1; k < NT; k++) begin
        tv_d[k]  = tv_q[k-1];
        t22_d[k] = t22_q[k-1];
        t23_d[k] = t23_q[k-1];
`ifdef C17_PIPE_PARITY_EN
        tpar_d[k] = tpar_q[k-1];
`endif
      end
    end

    cnt_d = cnt_q;
    if (tv_q[NT-1] && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      n2r_q <= '0;
      n7r_q <= '0;
      v2_q  <= 1'b0;
      c2_q  <= '0;
      d2_q  <= '0;
      a2_q  <= '0;
      for (int unsigned k = 0; k < NT; k++) begin
        tv_q[k]  <= 1'b0;
        t22_q[k] <= '0;
        t23_q[k] <= '0;
`ifdef C17_PIPE_PARITY_EN
        tpar_q[k] <= 1'b0;
`endif
      end
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      n2r_q <= n2r_d;
      n7r_q <= n7r_d;
      v2_q  <= v2_d;
      c2_q  <= c2_d;
      d2_q  <= d2_d;
      a2_q  <= a2_d;
      for (int unsigned k = 0; k < NT; k++) begin
        tv_q[k]  <= tv_d[k];
        t22_q[k] <= t22_d[k];
        t23_q[k] <= t23_d[k];
`ifdef C17_PIPE_PARITY_EN
        tpar_q[k] <= tpar_d[k];
`endif
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
